// File: rtl/merge_pipe.sv
// merge_pipe: two-stage unsigned add/subtract pipeline with valid/ready flow control and a transfer counter.
// Optional macro MERGE_PIPE_SATURATE_EN clamps overflowing results (all-ones for add, zero for subtract).
module merge_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Handshake: a transfer happens on a rising clk edge where valid and ready are both 1.
    // A raised valid holds its data stable until taken; ready never looks at the same side's valid.

    logic             v1;
    logic             v2;
    logic             sel_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;

    logic             adv1;
    logic             adv2;
    logic             out_xfer;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] res_out;
    logic             res_ovf;

    always_comb begin
        adv2     = !v2 || out_ready;
        adv1     = !v1 || adv2;
        in_ready = adv1;
        out_xfer = v2 && out_ready;
    end

    // The extra top bit of the difference is the borrow, i.e. opa_r < opb_r.
    always_comb begin
        sum_w   = {1'b0, opa_r} + {1'b0, opb_r};
        diff_w  = {1'b0, opa_r} - {1'b0, opb_r};
        res_ovf = sel_r ? sum_w[WIDTH] : diff_w[WIDTH];
        res_out = sel_r ? sum_w[WIDTH-1:0] : diff_w[WIDTH-1:0];
`ifdef MERGE_PIPE_SATURATE_EN
        if (res_ovf) begin
            res_out = sel_r ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sel_r <= 1'b0;
            opa_r <= '0;
            opb_r <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                sel_r <= sel;
                opa_r <= opa;
                opb_r <= opb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            out <= '0;
            ovf <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out <= res_out;
                ovf <= res_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (out_xfer) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_merge_pipe.sv
// Bench for merge_pipe: queue-based reference model checked every cycle plus directed literal checks.
// Honours MERGE_PIPE_SATURATE_EN the same way as the design.
module tb_merge_pipe;

`ifdef MERGE_PIPE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sel = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        ovf;
    logic [15:0] xfer_cnt;

    logic        d4_in_ready;
    logic        d4_out_valid;
    logic [31:0] d4_out;
    logic        d4_ovf;
    logic [3:0]  d4_xfer_cnt;

    int n_checks = 0;
    int n_errors = 0;

    merge_pipe #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .opa(opa), .opb(opb), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .ovf(ovf), .xfer_cnt(xfer_cnt)
    );

    merge_pipe #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d4_in_ready),
        .sel(sel), .opa(opa), .opb(opb), .out_valid(d4_out_valid),
        .out_ready(out_ready), .out(d4_out), .ovf(d4_ovf), .xfer_cnt(d4_xfer_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout required finish");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Result from plain integer arithmetic: {ovf, out}
    function automatic logic [32:0] calc(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint r;
        logic o;
        logic [31:0] v;
        if (s) begin
            r = longint'(a) + longint'(b);
            o = (r >= 64'sd4294967296);
        end else begin
            r = longint'(a) - longint'(b);
            o = (a < b);
        end
        v = r[31:0];
        if (SAT && o) v = s ? 32'hFFFF_FFFF : 32'h0;
        return {o, v};
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int          exp_e[$];
    int          edge_n = 0;
    int          cnt = 0;

    always @(posedge clk) edge_n++;

    // Each accepted item appears on the output one edge after acceptance when it is the oldest;
    // the pipe holds at most two items and takes a new one whenever it is not full or draining.
    always @(negedge clk) begin
        logic exp_ov;
        logic exp_ir;
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_xfer_cnt", xfer_cnt, 16'h0);
            check("rst_xfer_cnt4", d4_xfer_cnt, 4'h0);
            exp_q.delete();
            exp_e.delete();
            cnt = 0;
        end else begin
            exp_ov = (exp_q.size() > 0) && (exp_e[0] < edge_n);
            exp_ir = (exp_q.size() < 2) || out_ready;
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, exp_ir);
            check("xfer_cnt", xfer_cnt, cnt % 65536);
            check("xfer_cnt4", d4_xfer_cnt, cnt % 16);
            if (exp_ov && out_valid) begin
                check("out", out, exp_q[0][31:0]);
                check("ovf", ovf, exp_q[0][32]);
            end
            if (exp_ov && out_ready) begin
                void'(exp_q.pop_front());
                void'(exp_e.pop_front());
                cnt++;
            end
            if (in_valid && exp_ir) begin
                exp_q.push_back(calc(sel, opa, opb));
                exp_e.push_back(edge_n + 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic        vec_sel[32];
    logic [31:0] vec_a[32];
    logic [31:0] vec_b[32];
    logic        log_ir[64];
    logic        log_ov[64];
    logic [31:0] log_out[64];
    logic        log_ovf[64];
    logic [31:0] out_log[$];
    logic        ovf_log[$];

    task automatic set_vec(input int i, input logic s, input logic [31:0] a, input logic [31:0] b);
        vec_sel[i] = s;
        vec_a[i]   = a;
        vec_b[i]   = b;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Offers vec[0..n-1] in order; out_ready in cycle c follows pat[c%16].
    task automatic stream(input int n, input logic [15:0] pat);
        int  idx;
        logic done;
        idx = 0;
        done = 1'b0;
        out_log.delete();
        ovf_log.delete();
        for (int c = 0; c < 64; c++) begin
            @(posedge clk);
            #1;
            if (idx == n && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            out_ready = pat[c % 16];
            if (idx < n) begin
                in_valid = 1'b1;
                sel = vec_sel[idx];
                opa = vec_a[idx];
                opb = vec_b[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            log_ir[c]  = in_ready;
            log_ov[c]  = out_valid;
            log_out[c] = out;
            log_ovf[c] = ovf;
            if (out_valid && out_ready) begin
                out_log.push_back(out);
                ovf_log.push_back(ovf);
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_done", done, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        do_reset();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_xfer_cnt", xfer_cnt, 16'd0);
        check("reset_in_ready", in_ready, 1'b1);

        // Single add: latency two cycles
        set_vec(0, 1'b1, 32'd5, 32'd7);
        stream(1, 16'hFFFF);
        check("lat_c0_out_valid", log_ov[0], 1'b0);
        check("lat_c1_out_valid", log_ov[1], 1'b0);
        check("lat_c2_out_valid", log_ov[2], 1'b1);
        check("lat_c2_out", log_out[2], 32'd12);
        check("lat_c2_ovf", log_ovf[2], 1'b0);
        check("lat_xfer_cnt", xfer_cnt, 16'd1);

        // Borrow and carry cases back to back
        set_vec(0, 1'b0, 32'd3, 32'd5);
        set_vec(1, 1'b1, 32'hFFFF_FFFF, 32'd2);
        stream(2, 16'hFFFF);
        check("sub_borrow_out", out_log[0], SAT ? 32'h0 : 32'hFFFF_FFFE);
        check("sub_borrow_ovf", ovf_log[0], 1'b1);
        check("add_carry_out", out_log[1], SAT ? 32'hFFFF_FFFF : 32'h1);
        check("add_carry_ovf", ovf_log[1], 1'b1);
        check("ovf_xfer_cnt", xfer_cnt, 16'd3);

        // Four back-to-back with out_ready low in cycles 2..4
        set_vec(0, 1'b1, 32'd10, 32'd20);
        set_vec(1, 1'b0, 32'd100, 32'd1);
        set_vec(2, 1'b1, 32'h8000_0000, 32'h8000_0000);
        set_vec(3, 1'b0, 32'd7, 32'd7);
        stream(4, 16'hFFE3);
        for (int c = 2; c <= 4; c++) begin
            check("stall_in_ready", log_ir[c], 1'b0);
            check("stall_out_valid", log_ov[c], 1'b1);
            check("stall_out", log_out[c], 32'd30);
        end
        check("stall_count", out_log.size(), 4);
        check("stall_res0", out_log[0], 32'd30);
        check("stall_res1", out_log[1], 32'd99);
        check("stall_res2", out_log[2], SAT ? 32'hFFFF_FFFF : 32'h0);
        check("stall_res3", out_log[3], 32'd0);
        check("stall_xfer_cnt", xfer_cnt, 16'd7);

        // Reset with both stages full
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 1'b1; opa = 32'd1000; opb = 32'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; sel = 1'b0; opa = 32'd50; opb = 32'd8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("full_out_valid", out_valid, 1'b1);
        check("full_out", out, 32'd1001);
        check("full_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1; sel = 1'b1; opa = 32'd9; opb = 32'd9;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_xfer_cnt", xfer_cnt, 16'd0);
        check("async_xfer_cnt4", d4_xfer_cnt, 4'd0);
        check("async_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_out_valid", out_valid, 1'b0);
        set_vec(0, 1'b1, 32'd1, 32'd1);
        stream(1, 16'hFFFF);
        check("post_rst_count", out_log.size(), 1);
        check("post_rst_res", out_log[0], 32'd2);
        check("post_rst_xfer_cnt", xfer_cnt, 16'd1);

        // Seventeen transfers with irregular backpressure: 4-bit counter wraps to 1
        do_reset();
        set_vec(0,  1'b1, 32'h0, 32'h0);
        set_vec(1,  1'b0, 32'h0, 32'h0);
        set_vec(2,  1'b0, 32'h0, 32'h1);
        set_vec(3,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_vec(4,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_vec(5,  1'b1, 32'h1, 32'hFFFF_FFFF);
        set_vec(6,  1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
        set_vec(7,  1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
        set_vec(8,  1'b1, 32'h1234_5678, 32'h8765_4321);
        set_vec(9,  1'b0, 32'hDEAD_BEEF, 32'h0000_BEEF);
        set_vec(10, 1'b1, 32'h0000_FFFF, 32'h1);
        set_vec(11, 1'b0, 32'h1, 32'h0);
        set_vec(12, 1'b1, 32'h7FFF_FFFF, 32'h1);
        set_vec(13, 1'b0, 32'd16, 32'd32);
        set_vec(14, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        set_vec(15, 1'b0, 32'h5555_5555, 32'hAAAA_AAAA);
        set_vec(16, 1'b1, 32'd2, 32'd3);
        stream(17, 16'hB6E5);
        check("wrap_count", out_log.size(), 17);
        check("wrap_res3", out_log[3], SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
        check("wrap_res3_ovf", ovf_log[3], 1'b1);
        check("wrap_res6", out_log[6], 32'h1);
        check("wrap_res14", out_log[14], 32'hFFFF_FFFF);
        check("wrap_res14_ovf", ovf_log[14], 1'b0);
        check("wrap_xfer_cnt", xfer_cnt, 16'd17);
        check("wrap_xfer_cnt4", d4_xfer_cnt, 4'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
